// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between icache and dcache, one word per grant.
// dcache has fixed priority; icache is forced in after STARVE_MAX consecutive dcache grants.
module ram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
    localparam logic [1:0] ACCESS     = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q;
    logic [3:0]  starve_q;
    logic        ren_q, wen_q;
    logic [31:0] addr_q, store_q;
    logic        d_req, pick_i, pick_d, done, i_done, d_done;

    assign d_req  = dREN || dWEN;
    assign pick_i = iREN && (!d_req || starve_q == STARVE_LIM);
    assign pick_d = d_req && !pick_i;
    assign done   = state_q != IDLE && ramstate == ACCESS;
    assign i_done = done && state_q == IGRANT;
    assign d_done = done && state_q == DGRANT;

    assign iwait    = !i_done;
    assign dwait    = !d_done;
    assign iload    = i_done ? ramload : '0;
    assign dload    = d_done ? ramload : '0;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
        end else if (state_q == IDLE) begin
            if (!iREN) starve_q <= '0;
            if (pick_i || pick_d) begin
                state_q <= pick_i ? IGRANT : DGRANT;
                ren_q   <= pick_i || !dWEN;
                wen_q   <= pick_d && dWEN;
                addr_q  <= pick_i ? iaddr : daddr;
                store_q <= dstore;
            end
        end else if (done) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            // starvation only accrues while icache is actually waiting
            if (i_done) starve_q <= '0;
            else if (iREN && starve_q != STARVE_LIM) starve_q <= starve_q + 4'd1;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized two-cache traffic against a transaction-level
// scoreboard and a grant-order model derived from the priority/starvation rules.
module tb_ram_arbiter;
    localparam int SM = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic CLK = 0, RST = 1, iREN = 0, dREN = 0, dWEN = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic iwait, dwait, ramREN, ramWEN;
    logic [1:0] ramstate = FREE;
    logic fixed_en = 0;
    logic [31:0] fixed_val = 0;
    bit arb_on = 0, ram_rand = 0, have_exp = 0;
    int vecs = 0, errs = 0, streak = 0, exp_own = 0;
    txn_t iq[$], dq[$];

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ {a[31:28], 28'h5A3C96E};
    endfunction

    assign ramload = fixed_en ? fixed_val : memf(ramaddr);

    ram_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] st);
        @(posedge CLK);
        #1 ramstate = st;
        @(negedge CLK);
    endtask

    // scoreboard monitor: pops on every completion cycle
    always @(negedge CLK) begin
        txn_t t;
        if (!RST) begin
            chk("strobe_excl", {31'd0, ramREN & ramWEN}, 0);
            chk("wait_excl", {31'd0, iwait | dwait}, 1);
            if (!iwait) begin
                if (iq.size() == 0) chk("i_unexpected", 1, 0);
                else begin
                    t = iq.pop_front();
                    chk("i_ren", {31'd0, ramREN}, 1);
                    chk("i_addr", ramaddr, t.addr);
                    chk("iload", iload, t.data);
                end
            end
            if (!dwait) begin
                if (dq.size() == 0) chk("d_unexpected", 1, 0);
                else begin
                    t = dq.pop_front();
                    chk("d_wen", {31'd0, ramWEN}, {31'd0, t.wr});
                    chk("d_ren", {31'd0, ramREN}, {31'd0, !t.wr});
                    chk("d_addr", ramaddr, t.addr);
                    if (t.wr) chk("d_store", ramstore, t.data);
                    else chk("dload", dload, t.data);
                end
            end
        end
    end

    // grant-order model: owner decided in each idle cycle, observed on the next
    always @(negedge CLK) begin
        int own;
        if (RST) begin
            streak   = 0;
            have_exp = 0;
        end else begin
            own = !(ramREN || ramWEN) ? 0 : (ramaddr[31:28] == 4'h0 ? 1 : 2);
            if (have_exp) begin
                chk("grant_owner", own, exp_own);
                have_exp = 0;
            end
            if (own == 0) begin
                if (!iREN) streak = 0;
                if (arb_on) begin
                    exp_own  = (iREN && (!(dREN || dWEN) || streak == SM)) ? 1 : ((dREN || dWEN) ? 2 : 0);
                    have_exp = 1;
                end
            end
            if (!dwait && iREN) streak = (streak == SM) ? SM : streak + 1;
            if (!iwait) streak = 0;
        end
    end

    task automatic i_drv(input int n);
        for (int t = 0; t < n; t++) begin
            int k, gap;
            @(posedge CLK);
            #1 gap = $urandom_range(0, 2);
            if (gap != 0) begin
                iREN = 0;
                repeat (gap) begin @(posedge CLK); #1; end
            end
            iaddr = {4'h0, 12'($urandom), 14'($urandom), 2'b00};
            iq.push_back('{1'b0, iaddr, memf(iaddr)});
            iREN = 1;
            k = 0;
            do begin @(negedge CLK); k++; end while (iwait && k < 200);
            if (iwait) chk("i_timeout", 1, 0);
        end
        @(posedge CLK);
        #1 iREN = 0;
    endtask

    task automatic d_drv(input int n);
        for (int t = 0; t < n; t++) begin
            int k;
            logic wr;
            @(posedge CLK);
            #1 if ($urandom_range(0, 4) == 0) begin
                dREN = 0; dWEN = 0;
                @(posedge CLK); #1;
            end
            wr = $urandom_range(0, 2) == 0;
            daddr  = {wr ? 4'h2 : 4'h1, 12'($urandom), 14'($urandom), 2'b00};
            dstore = $urandom;
            dWEN   = wr;
            dREN   = wr ? 1'($urandom) : 1'b1;
            dq.push_back('{wr, daddr, wr ? dstore : memf(daddr)});
            k = 0;
            do begin @(negedge CLK); k++; end while (dwait && k < 200);
            if (dwait) chk("d_timeout", 1, 0);
        end
        @(posedge CLK);
        #1 begin dREN = 0; dWEN = 0; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values, then reset asserted in the middle of a dcache grant
        @(negedge CLK);
        chk("rst_iwait", {31'd0, iwait}, 1);
        chk("rst_dwait", {31'd0, dwait}, 1);
        chk("rst_ren", {31'd0, ramREN}, 0);
        chk("rst_wen", {31'd0, ramWEN}, 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_store", ramstore, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        dREN = 1; daddr = 32'h100;
        step(BUSY);
        chk("t1_ren_granted", {31'd0, ramREN}, 1);
        #2 RST = 1;
        #1;
        chk("t1_ren_async", {31'd0, ramREN}, 0);
        chk("t1_wen_async", {31'd0, ramWEN}, 0);
        chk("t1_iwait", {31'd0, iwait}, 1);
        chk("t1_dwait", {31'd0, dwait}, 1);
        dREN = 0;
        @(posedge CLK);
        #1 RST = 0;
        step(FREE);
        chk("t1_idle_ren", {31'd0, ramREN}, 0);
        chk("t1_idle_addr", ramaddr, 0);

        // icache fetch with two BUSY cycles
        fixed_en = 1; fixed_val = 32'h8C010004;
        iREN = 1; iaddr = 32'h40;
        iq.push_back('{1'b0, 32'h40, 32'h8C010004});
        for (int c = 1; c <= 3; c++) begin
            step(c == 3 ? ACCESS : BUSY);
            chk("t2_ren", {31'd0, ramREN}, 1);
            chk("t2_addr", ramaddr, 32'h40);
            chk("t2_iwait", {31'd0, iwait}, {31'd0, c != 3});
        end
        iREN = 0;
        step(FREE);
        chk("t2_idle_iwait", {31'd0, iwait}, 1);
        chk("t2_idle_ren", {31'd0, ramREN}, 0);
        fixed_en = 0;

        // dcache write wins over read
        dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        dq.push_back('{1'b1, 32'h100, 32'hDEADBEEF});
        step(BUSY);
        chk("t3_wen", {31'd0, ramWEN}, 1);
        chk("t3_ren", {31'd0, ramREN}, 0);
        chk("t3_store", ramstore, 32'hDEADBEEF);
        step(ACCESS);
        dWEN = 0; dREN = 0;
        step(FREE);

        // ERROR retries keep strobes and address
        iREN = 1; iaddr = 32'h80;
        iq.push_back('{1'b0, 32'h80, memf(32'h80)});
        repeat (3) begin
            step(ERROR);
            chk("t5_ren", {31'd0, ramREN}, 1);
            chk("t5_addr", ramaddr, 32'h80);
            chk("t5_iwait", {31'd0, iwait}, 1);
        end
        step(ACCESS);
        chk("t5_done", {31'd0, iwait}, 0);
        iREN = 0;
        step(FREE);

        // dcache drops its request mid-grant; icache then gets in
        dREN = 1; daddr = 32'h100;
        dq.push_back('{1'b0, 32'h100, memf(32'h100)});
        step(BUSY);
        dREN = 0; daddr = 32'h200; iREN = 1; iaddr = 32'h44;
        iq.push_back('{1'b0, 32'h44, memf(32'h44)});
        step(BUSY);
        chk("t6_addr_held", ramaddr, 32'h100);
        step(ACCESS);
        step(FREE);
        chk("t6_idle_ren", {31'd0, ramREN}, 0);
        step(ACCESS);
        chk("t6_i_addr", ramaddr, 32'h44);
        iREN = 0;
        step(FREE);

        // both held: four dcache grants, one icache, then dcache again
        iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h104;
        for (int g = 0; g < 6; g++) begin
            if (g == 4) iq.push_back('{1'b0, 32'h48, memf(32'h48)});
            else dq.push_back('{1'b0, 32'h104, memf(32'h104)});
        end
        for (int g = 0; g < 6; g++) begin
            step(BUSY);
            chk("t4_owner_addr", ramaddr, g == 4 ? 32'h48 : 32'h104);
            step(ACCESS);
            if (g == 5) begin iREN = 0; dREN = 0; end
            step(FREE);
        end

        // randomized traffic from both caches
        arb_on = 1; ram_rand = 1;
        fork
            begin
                fork
                    i_drv(80);
                    d_drv(120);
                join
                ram_rand = 0;
            end
            begin
                while (ram_rand) begin
                    int r;
                    @(posedge CLK);
                    #1 r = $urandom_range(0, 19);
                    ramstate = r < 8 ? ACCESS : (r < 14 ? BUSY : (r < 17 ? FREE : ERROR));
                end
            end
        join
        ramstate = ACCESS;
        repeat (4) @(negedge CLK);
        arb_on = 0;
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
